// File: rtl/vga_tile_renderer.sv
// Pixel back end: board RAM with power-on clear, tile staging, palette lookup, sync alignment.
// Latency: row/col presented in cycle t are reflected on hsync_n/vsync_n/r/g/b in cycle t+2.
// Backpressure: none; the controller paces re/update_state/updateoutput, a missed tile sets underrun.
module vga_tile_renderer #(
    parameter int          HACTIVE = 640,
    parameter int          HFP     = 16,
    parameter int          HSYNC   = 96,
    parameter int          VACTIVE = 480,
    parameter int          VFP     = 10,
    parameter int          VSYNC   = 2,
    parameter int          BLOCK   = 20,
    parameter logic [11:0] C_EMPTY = 12'h000,
    parameter logic [11:0] C_BODY  = 12'h0F0,
    parameter logic [11:0] C_HEAD  = 12'hFF0,
    parameter logic [11:0] C_FOOD  = 12'hF00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] row,
    input  logic [9:0] col,
    input  logic [9:0] raddr,
    input  logic       re,
    input  logic       update_state,
    input  logic       updateoutput,
    input  logic       we,
    input  logic [9:0] waddr,
    input  logic [1:0] wdata,
    output logic       busy,
    output logic       underrun,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic [3:0] r,
    output logic [3:0] g,
    output logic [3:0] b
);

    localparam logic [9:0] H_ACT  = 10'(HACTIVE);
    localparam logic [9:0] H_SS   = 10'(HACTIVE + HFP);
    localparam logic [9:0] H_SE   = 10'(HACTIVE + HFP + HSYNC);
    localparam logic [9:0] V_ACT  = 10'(VACTIVE);
    localparam logic [9:0] V_SS   = 10'(VACTIVE + VFP);
    localparam logic [9:0] V_SE   = 10'(VACTIVE + VFP + VSYNC);
    localparam int         BCW    = $clog2(BLOCK);
    localparam logic [BCW-1:0] BLK_LAST = BCW'(BLOCK - 1);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    // Board clear state machine
    logic [0:0] state_q, state_d;
    logic [9:0] clr_addr_q, clr_addr_d;

    // Board storage and read port
    logic [1:0] mem_q [0:1023];
    logic [1:0] rdata_q;
    logic       mem_we;
    logic [9:0] mem_waddr;
    logic [1:0] mem_wdata;

    // Tile staging
    logic [BCW-1:0] blk_q, blk_d, blk_phase;
    logic [1:0]     cur_tile_q, cur_tile_d;
    logic [1:0]     next_tile_q, next_tile_d;
    logic           next_valid_q, next_valid_d;
    logic           underrun_q, underrun_d;

    // Pixel pipeline
    logic        active, boundary, hs, vs;
    logic        active_q, hs_q, vs_q;
    logic        hsync_n_q, vsync_n_q;
    logic [11:0] pal_rgb;
    logic [11:0] rgb_q;

    // Clear walks every address once after reset, then hands the RAM to the game
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == ST_CLEAR) begin
            clr_addr_d = clr_addr_q + 10'd1;
            if (clr_addr_q == 10'd1023) begin
                state_d = ST_IDLE;
            end
        end
    end

    // Clear state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= 10'd0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign busy      = (state_q == ST_CLEAR);
    assign mem_we    = busy | we;
    assign mem_waddr = busy ? clr_addr_q : waddr;
    assign mem_wdata = busy ? 2'd0 : wdata;

    // RAM write port; game writes are shadowed by the clear walk while busy
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Synchronous read; a colliding write lands after the read, so old data is returned
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    // Tile phase counter realigns at row 0 so a boundary hits every BLOCK pixels
    always_comb begin
        active    = (row < H_ACT) && (col < V_ACT);
        blk_phase = (row == 10'd0) ? '0 : blk_q;
        blk_d     = (blk_phase == BLK_LAST) ? '0 : blk_phase + BCW'(1);
        boundary  = active && (blk_phase == '0);
        hs        = (row >= H_SS) && (row < H_SE);
        vs        = (col >= V_SS) && (col < V_SE);
    end

    // Promote the staged tile at each boundary; load a new one on update_state
    always_comb begin
        cur_tile_d   = cur_tile_q;
        next_tile_d  = next_tile_q;
        next_valid_d = next_valid_q;
        underrun_d   = underrun_q;
        if (boundary) begin
            next_valid_d = 1'b0;
            if (next_valid_q) begin
                cur_tile_d = next_tile_q;
            end else begin
                cur_tile_d = 2'd0;
                underrun_d = 1'b1;
            end
        end
        if (update_state) begin
            next_tile_d  = rdata_q;
            next_valid_d = 1'b1;
        end
    end

    // Stage-1 registers: tile state, active flag and raw sync windows
    always_ff @(posedge clk) begin
        if (reset) begin
            blk_q        <= '0;
            cur_tile_q   <= 2'd0;
            next_tile_q  <= 2'd0;
            next_valid_q <= 1'b0;
            underrun_q   <= 1'b0;
            active_q     <= 1'b0;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
        end else begin
            blk_q        <= blk_d;
            cur_tile_q   <= cur_tile_d;
            next_tile_q  <= next_tile_d;
            next_valid_q <= next_valid_d;
            underrun_q   <= underrun_d;
            active_q     <= active;
            hs_q         <= hs;
            vs_q         <= vs;
        end
    end

    // Fixed palette, every 2-bit code has a colour
    always_comb begin
        pal_rgb = C_EMPTY;
        case (cur_tile_q)
            2'd0: pal_rgb = C_EMPTY;
            2'd1: pal_rgb = C_BODY;
            2'd2: pal_rgb = C_HEAD;
            2'd3: pal_rgb = C_FOOD;
            default: pal_rgb = C_EMPTY;
        endcase
    end

    // Stage-2 outputs: syncs always advance, colour only when the controller enables it
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_n_q <= 1'b1;
            vsync_n_q <= 1'b1;
            rgb_q     <= 12'h000;
        end else begin
            hsync_n_q <= ~hs_q;
            vsync_n_q <= ~vs_q;
            if (updateoutput) begin
                rgb_q <= active_q ? pal_rgb : 12'h000;
            end
        end
    end

    assign underrun = underrun_q;
    assign hsync_n  = hsync_n_q;
    assign vsync_n  = vsync_n_q;
    assign r        = rgb_q[11:8];
    assign g        = rgb_q[7:4];
    assign b        = rgb_q[3:0];

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Bench for vga_tile_renderer: directed scenarios plus randomized frames against a reference model.
// Outputs are sampled 1 time unit after the rising edge; after driving row x they reflect row x-1.
// All waits are fixed cycle loops, so the run always reaches the summary line.
module tb_vga_tile_renderer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] row = 10'd645;
    logic [9:0] col = 10'd0;
    logic [9:0] raddr = 10'd0;
    logic       re = 1'b0;
    logic       update_state = 1'b0;
    logic       updateoutput = 1'b1;
    logic       we = 1'b0;
    logic [9:0] waddr = 10'd0;
    logic [1:0] wdata = 2'd0;
    logic       busy, underrun, hsync_n, vsync_n;
    logic [3:0] r, g, b;

    always #5 clk = ~clk;

    vga_tile_renderer dut (
        .clk          (clk),
        .reset        (reset),
        .row          (row),
        .col          (col),
        .raddr        (raddr),
        .re           (re),
        .update_state (update_state),
        .updateoutput (updateoutput),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
        .busy         (busy),
        .underrun     (underrun),
        .hsync_n      (hsync_n),
        .vsync_n      (vsync_n),
        .r            (r),
        .g            (g),
        .b            (b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state, written from the behavioural rules
    logic [1:0]  mdl_mem [1024];
    int          mdl_k = 0;
    logic [1:0]  mdl_rd = 2'd0, mdl_cur = 2'd0, mdl_nt = 2'd0;
    bit          mdl_nv = 1'b0, mdl_und = 1'b0;
    logic [11:0] mdl_rgb = 12'h000, p_rgb = 12'h000;
    bit          mdl_hs_n = 1'b1, mdl_vs_n = 1'b1, p_hs_n = 1'b1, p_vs_n = 1'b1;
    int          pick = 0;

    wire [14:0] obs = {r, g, b, hsync_n, vsync_n, underrun};

    function automatic logic [11:0] colour(input logic [1:0] code);
        case (code)
            2'd1:    return 12'h0F0;
            2'd2:    return 12'hFF0;
            2'd3:    return 12'hF00;
            default: return 12'h000;
        endcase
    endfunction

    function automatic logic [14:0] expv();
        return {mdl_rgb, mdl_hs_n, mdl_vs_n, mdl_und};
    endfunction

    // Advance one clock, updating the model with this cycle's inputs
    task automatic tick();
        bit act, bnd;
        act = (row < 10'd640) && (col < 10'd480);
        bnd = act && ((int'(row) % 20) == 0);
        if (reset) begin
            mdl_k = 0; mdl_cur = 2'd0; mdl_nt = 2'd0; mdl_nv = 1'b0; mdl_und = 1'b0;
            mdl_rgb = 12'h000; mdl_hs_n = 1'b1; mdl_vs_n = 1'b1;
            p_rgb = 12'h000; p_hs_n = 1'b1; p_vs_n = 1'b1;
        end else begin
            if (updateoutput) mdl_rgb = p_rgb;
            mdl_hs_n = p_hs_n;
            mdl_vs_n = p_vs_n;
            if (bnd) begin
                if (mdl_nv) mdl_cur = mdl_nt;
                else begin mdl_cur = 2'd0; mdl_und = 1'b1; end
            end
            if (update_state) begin mdl_nt = mdl_rd; mdl_nv = 1'b1; end
            else if (bnd) mdl_nv = 1'b0;
            p_rgb  = act ? colour(mdl_cur) : 12'h000;
            p_hs_n = !((row >= 656) && (row < 752));
            p_vs_n = !((col >= 490) && (col < 492));
        end
        if (re) mdl_rd = mdl_mem[raddr];
        if (!reset) begin
            if (mdl_k < 1024) mdl_mem[mdl_k] = 2'd0;
            else if (we) mdl_mem[waddr] = wdata;
            mdl_k++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        row = 10'd645; col = 10'd0; re = 0; update_state = 0; we = 0;
        reset = 1'b1; tick(); reset = 1'b0;
        repeat (1024) tick();
    endtask

    task automatic write_mem(input logic [9:0] a, input logic [1:0] d);
        we = 1'b1; waddr = a; wdata = d; tick(); we = 1'b0;
    endtask

    // Stage a tile during blanking so the first boundary of the next line has data
    task automatic prestage(input logic [9:0] a);
        row = 10'd645; re = 1'b1; raddr = a; tick();
        re = 1'b0; update_state = 1'b1; tick();
        update_state = 1'b0;
    endtask

    // Controller-like fetch: read two pixels before a boundary, stage one pixel before it
    task automatic ctl_stage(input int x, input logic [9:0] a);
        re = ((x % 20) == 18);
        raddr = a;
        update_state = ((x % 20) == 19);
    endtask

    task automatic test_reset();
        updateoutput = 1'b1; reset = 1'b1; tick();
        checks++;
        if (obs !== {12'h000, 1'b1, 1'b1, 1'b0})
            begin errors++; $display("FAIL reset_outputs got=%h want=%h", obs, {12'h000, 3'b110}); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b want=1", busy); end
        reset = 1'b0;
        for (int k = 0; k < 1030; k++) begin
            we = (k == 10); waddr = 10'd5; wdata = 2'd3;
            tick();
            checks++;
            if (busy !== (mdl_k < 1024))
                begin errors++; $display("FAIL clear_busy k=%0d got=%b want=%b", k, busy, mdl_k < 1024); end
        end
        we = 1'b0;
    endtask

    task automatic test_sync_sweep();
        int hs_low, vs_low;
        prestage(10'd5);
        hs_low = 0;
        for (int x = 0; x < 800; x++) begin
            row = 10'(x); col = 10'd0; tick();
            if (hsync_n === 1'b0) hs_low++;
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL hsweep x=%0d got=%h want=%h", x, obs, expv()); end
            if (x == 7) begin
                checks++;
                if ({r, g, b} !== 12'h000)
                    begin errors++; $display("FAIL ignored_write rgb got=%h want=000", {r, g, b}); end
            end
        end
        checks++;
        if (hs_low != 96) begin errors++; $display("FAIL hsync_width got=%0d want=96", hs_low); end
        for (int c = 488; c < 494; c++) begin
            vs_low = 0;
            for (int x = 0; x < 800; x++) begin
                row = 10'(x); col = 10'(c); tick();
                if (x >= 2 && vsync_n === 1'b0) vs_low++;
                checks++;
                if (obs !== expv()) begin errors++; $display("FAIL vsweep c=%0d x=%0d got=%h want=%h", c, x, obs, expv()); end
            end
            checks++;
            if (vs_low != (((c == 490) || (c == 491)) ? 798 : 0))
                begin errors++; $display("FAIL vsync_line c=%0d got=%0d", c, vs_low); end
        end
    endtask

    task automatic test_tile_fetch();
        do_reset();
        write_mem(10'd33, 2'd3);
        write_mem(10'd0, 2'd2);
        prestage(10'd0);
        for (int x = 0; x < 40; x++) begin
            row = 10'(x); col = 10'd0;
            re = (x == 17); raddr = 10'd33; update_state = (x == 18);
            tick();
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL tile_fetch x=%0d got=%h want=%h", x, obs, expv()); end
            if (x >= 1) begin
                checks++;
                if ({r, g, b} !== ((x <= 20) ? 12'hFF0 : 12'hF00))
                    begin errors++; $display("FAIL tile_colour x=%0d got=%h", x, {r, g, b}); end
            end
        end
        update_state = 1'b0; re = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL no_underrun_yet got=%b want=0", underrun); end
    endtask

    task automatic test_underrun();
        for (int x = 40; x < 800; x++) begin
            row = 10'(x); tick();
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL underrun_line x=%0d got=%h want=%h", x, obs, expv()); end
            if (x <= 60) begin
                checks++;
                if ({r, g, b} !== ((x == 40) ? 12'hF00 : 12'h000))
                    begin errors++; $display("FAIL underrun_rgb x=%0d got=%h", x, {r, g, b}); end
            end
            if (x == 40) begin
                checks++;
                if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set got=%b want=1", underrun); end
            end
        end
        prestage(10'd0);
        for (int x = 0; x < 800; x++) begin
            row = 10'(x); col = 10'd1; ctl_stage(x, 10'd33); tick();
        end
        re = 1'b0; update_state = 1'b0;
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky got=%b want=1", underrun); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        write_mem(10'd1, 2'd1);
        write_mem(10'd2, 2'd2);
        write_mem(10'd3, 2'd3);
        prestage(10'd1);
        for (int x = 0; x < 800; x++) begin
            row = 10'(x); col = 10'd0;
            if (x <= 40) begin
                re = (x == 10) || (x == 19);
                raddr = (x == 10) ? 10'd2 : 10'd3;
                update_state = (x == 11) || (x == 20);
            end else begin
                ctl_stage(x, 10'($urandom_range(0, 3)));
            end
            tick();
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL b2b x=%0d got=%h want=%h", x, obs, expv()); end
            if (x >= 1 && x <= 60) begin
                checks++;
                if ({r, g, b} !== ((x <= 20) ? 12'h0F0 : (x <= 40) ? 12'hFF0 : 12'hF00))
                    begin errors++; $display("FAIL b2b_colour x=%0d got=%h", x, {r, g, b}); end
            end
        end
        re = 1'b0; update_state = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL b2b_underrun got=%b want=0", underrun); end
    endtask

    task automatic test_random_frames();
        for (int ln = 0; ln < 6; ln++) begin
            col = 10'($urandom_range(0, 524));
            for (int x = 0; x < 800; x++) begin
                row = 10'(x);
                we = ($urandom_range(0, 15) == 0);
                waddr = 10'($urandom_range(0, 15));
                wdata = 2'($urandom_range(0, 3));
                updateoutput = ($urandom_range(0, 7) != 0);
                if ((x % 20) == 17) pick = $urandom_range(0, 7);
                re = ((x % 20) == 18) || ($urandom_range(0, 7) == 0);
                raddr = 10'($urandom_range(0, 15));
                update_state = ((pick < 5) && ((x % 20) == 19)) || ((pick == 5 || pick == 6) && ((x % 20) == 0));
                tick();
                checks++;
                if (obs !== expv()) begin errors++; $display("FAIL random ln=%0d x=%0d got=%h want=%h", ln, x, obs, expv()); end
            end
        end
        we = 1'b0; re = 1'b0; update_state = 1'b0; updateoutput = 1'b1;
    endtask

    task automatic test_reset_midframe();
        prestage(10'd2);
        for (int x = 0; x <= 300; x++) begin
            row = 10'(x); col = 10'd100; ctl_stage(x, 10'(x % 4));
            reset = (x == 300);
            tick();
        end
        checks++;
        if (obs !== {12'h000, 1'b1, 1'b1, 1'b0})
            begin errors++; $display("FAIL midframe_reset got=%h want=%h", obs, {12'h000, 3'b110}); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midframe_busy got=%b want=1", busy); end
        reset = 1'b0; re = 1'b0; update_state = 1'b0; row = 10'd645;
        for (int k = 0; k < 1600; k++) begin
            reset = (k == 500);
            tick();
            checks++;
            if (busy !== (mdl_k < 1024))
                begin errors++; $display("FAIL reclear_busy k=%0d got=%b want=%b", k, busy, mdl_k < 1024); end
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL reclear_out k=%0d got=%h want=%h", k, obs, expv()); end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sync_sweep();
        test_tile_fetch();
        test_underrun();
        test_back_to_back();
        test_random_frames();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
